fp_normalize: RTL and testbench

- Multi-cycle front end of the 12-bit linear-to-8-bit floating-point converter.
- Accepts a 12-bit two's-complement sample over a valid/ready handshake and converts it to sign-magnitude, saturating -2048.
- Normalises the magnitude by iterative left shift, one bit per cycle, and presents sign, 3-bit exponent, 4-bit significand and fifth (round) bit.
- Output feeds the downstream rounding stage directly.

---
 rtl/fp_normalize_if.sv | 20 ++
 rtl/fp_normalize.sv | 73 +++++++
 tb/tb_fp_normalize.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fp_normalize_if.sv
// fp_normalize_if: sample-in / float-fields-out handshake bundle for fp_normalize
interface fp_normalize_if;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] sample_in;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [2:0]  exponent_out;
  logic [3:0]  significand_out;
  logic        fifth_bit_out;
  modport master (
    output in_valid, sample_in, out_ready,
    input  in_ready, out_valid, sign_out, exponent_out, significand_out, fifth_bit_out
  );
  modport slave (
    input  in_valid, sample_in, out_ready,
    output in_ready, out_valid, sign_out, exponent_out, significand_out, fifth_bit_out
  );
endinterface

// File: rtl/fp_normalize.sv
// fp_normalize: 12-bit two's-complement sample to sign/exp/significand/round-bit, one shift per cycle
module fp_normalize (
  input logic            clk,
  input logic            rst_n,
  fp_normalize_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ABS, NORM, DONE} state_t;
  state_t      state, state_nx;
  logic [11:0] raw_q;
  logic [10:0] mag_q, mag_abs;
  logic [2:0]  exp_q;
  logic        norm_done;
  logic        out_valid_q, sign_q, fifth_q;
  logic [2:0]  exp_out_q;
  logic [3:0]  sig_q;
  // -2048 has no positive counterpart in 12 bits, so it clamps to 2047
  assign mag_abs   = !raw_q[11] ? raw_q[10:0] :
                     (raw_q[10:0] == 11'd0) ? 11'h7FF : ~raw_q[10:0] + 11'd1;
  assign norm_done = mag_q[10] | (exp_q == 3'd0);
  assign bus.in_ready        = (state == IDLE) & rst_n;
  assign bus.out_valid       = out_valid_q;
  assign bus.sign_out        = sign_q;
  assign bus.exponent_out    = exp_out_q;
  assign bus.significand_out = sig_q;
  assign bus.fifth_bit_out   = fifth_q;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  // next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.in_valid ? ABS : IDLE;
      ABS:     state_nx = NORM;
      NORM:    state_nx = norm_done ? DONE : NORM;
      DONE:    state_nx = bus.out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // capture, absolute value, normalising shift and result registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      raw_q       <= '0;
      mag_q       <= '0;
      exp_q       <= '0;
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      exp_out_q   <= '0;
      sig_q       <= '0;
      fifth_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) raw_q <= bus.sample_in;
        ABS: begin
          mag_q <= mag_abs;
          exp_q <= 3'd7;
        end
        NORM: if (norm_done) begin
          sig_q       <= mag_q[10:7];
          fifth_q     <= mag_q[6];
          exp_out_q   <= exp_q;
          sign_q      <= raw_q[11];
          out_valid_q <= 1'b1;
        end else begin
          mag_q <= {mag_q[9:0], 1'b0};
          exp_q <= exp_q - 3'd1;
        end
        DONE: if (bus.out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_fp_normalize.sv
// tb_fp_normalize: random and directed stimulus against a behavioural float-conversion model
module tb_fp_normalize;
  typedef struct packed {
    logic       s;
    logic [2:0] e;
    logic [3:0] m;
    logic       f;
    logic [3:0] lat;
  } res_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   busy = 1'b0;
  bit   rnd = 1'b0;
  int   cyc = 0;
  int   acc = 0;
  res_t cur = '0;
  res_t last = '0;
  fp_normalize_if bus ();
  fp_normalize dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // reference: value from magnitude, exponent from highest set bit, latency from shift count
  function automatic res_t model(input logic [11:0] x);
    res_t r;
    int v, mag, p, e, norm;
    v    = x[11] ? int'(x) - 4096 : int'(x);
    mag  = v < 0 ? -v : v;
    if (mag > 2047) mag = 2047;
    p = -1;
    for (int i = 0; i < 11; i++) if (mag >= (1 << i)) p = i;
    e    = p >= 3 ? p - 3 : 0;
    norm = mag << (7 - e);
    r.s   = x[11];
    r.e   = e[2:0];
    r.m   = 4'((norm >> 7) & 15);
    r.f   = ((norm >> 6) & 1) == 1;
    r.lat = 4'(9 - e);
    return r;
  endfunction
  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask
  task automatic pin(input logic [11:0] x, input res_t want);
    res_t got;
    got = model(x);
    check($sformatf("model_%03h", x), int'(got), int'(want));
  endtask
  // model state: one transaction in flight, accepted only when idle
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      cur  <= '0;
      last <= '0;
    end else begin
      cyc <= cyc + 1;
      if (busy && (cyc - acc) >= int'(cur.lat) && bus.out_ready) begin
        busy <= 1'b0;
        last <= cur;
      end else if (!busy && bus.in_valid) begin
        busy <= 1'b1;
        cur  <= model(bus.sample_in);
        acc  <= cyc + 1;
      end
    end
  // compare every cycle: handshake flags and the presented fields
  always @(negedge clk) begin
    bit   ev;
    res_t w;
    ev = busy && (cyc - acc) >= int'(cur.lat);
    w  = ev ? cur : last;
    check("in_ready", int'(bus.in_ready), int'(!busy && rst_n));
    check("out_valid", int'(bus.out_valid), int'(ev));
    check("fields", int'({bus.sign_out, bus.exponent_out, bus.significand_out, bus.fifth_bit_out}),
          int'({w.s, w.e, w.m, w.f}));
  end
  task automatic step();
    @(negedge clk);
    if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic send(input logic [11:0] s);
    int n;
    n = 0;
    while (!bus.in_ready && n < 60) begin step(); n++; end
    check("send_timeout", int'(n >= 60), 0);
    bus.in_valid  = 1'b1;
    bus.sample_in = s;
    step();
    bus.in_valid  = 1'b0;
    bus.sample_in = 12'($urandom);
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin step(); n++; end
    check("idle_timeout", int'(n >= 60), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [11:0] s;
    bus.in_valid  = 1'b0;
    bus.sample_in = '0;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_fields", int'({bus.sign_out, bus.exponent_out, bus.significand_out, bus.fifth_bit_out}), 0);
    pin(12'h7FF, '{1'b0, 3'd7, 4'hF, 1'b1, 4'd2});
    pin(12'h800, '{1'b1, 3'd7, 4'hF, 1'b1, 4'd2});
    pin(12'h02E, '{1'b0, 3'd2, 4'hB, 1'b1, 4'd7});
    pin(12'hFFF, '{1'b1, 3'd0, 4'h1, 1'b0, 4'd9});
    pin(12'h000, '{1'b0, 3'd0, 4'h0, 1'b0, 4'd9});
    pin(12'h100, '{1'b0, 3'd5, 4'h8, 1'b0, 4'd4});
    pin(12'h801, '{1'b1, 3'd7, 4'hF, 1'b1, 4'd2});
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", int'(bus.in_ready), 1);
    send(12'h7FF); wait_idle();
    send(12'h800); wait_idle();
    send(12'h02E); wait_idle();
    send(12'hFFF); wait_idle();
    send(12'h801); wait_idle();
    send(12'h000);
    repeat (3) step();
    bus.in_valid  = 1'b1;
    bus.sample_in = 12'h123;
    step();
    bus.in_valid  = 1'b0;
    wait_idle();
    bus.out_ready = 1'b0;
    send(12'h7FF);
    repeat (8) step();
    check("bp_held_valid", int'(bus.out_valid), 1);
    bus.in_valid  = 1'b1;
    bus.sample_in = 12'h555;
    bus.out_ready = 1'b1;
    step();
    step();
    bus.in_valid  = 1'b0;
    wait_idle();
    send(12'h001);
    repeat (3) step();
    #3 rst_n = 1'b0;
    #1;
    check("abort_out_valid", int'(bus.out_valid), 0);
    check("abort_in_ready", int'(bus.in_ready), 0);
    check("abort_fields", int'({bus.sign_out, bus.exponent_out, bus.significand_out, bus.fifth_bit_out}), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("release_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    send(12'h100); wait_idle();
    check("last_100", int'({bus.sign_out, bus.exponent_out, bus.significand_out, bus.fifth_bit_out}),
          int'({1'b0, 3'd5, 4'h8, 1'b0}));
    rnd = 1'b1;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) step();
      s = 12'($urandom);
      if ($urandom_range(0, 1) == 1) s = s >> $urandom_range(0, 11);
      send(s);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    rnd = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
